// File: rtl/ddr_capture_fifo.sv
// Dual-edge input capture: pairs posedge/negedge samples into one word and
// buffers the words in a DEPTH-entry FIFO that drains on a valid/ready port.
//
// Ports:
//   clk        single clock; both edges are used for capture
//   rst        synchronous active-high reset
//   en         capture enable, sampled at posedge
//   data       WIDTH-bit sampled bus
//   out_ready  consumer accepts the head word
//   out_valid  FIFO non-empty
//   out_data   head word {neg_sample, pos_sample}; zero when empty
//   out_level  current occupancy
//   overflow   sticky; set when a pair was dropped
//   q_pos      posedge capture register (monitor)
//   q_neg      negedge capture register (monitor)
module ddr_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DDR   = 1,
  parameter logic [WIDTH-1:0] POS_INIT = '0,
  parameter logic [WIDTH-1:0] NEG_INIT = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [2*WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0]   out_level,
  output logic                     overflow,
  output logic [WIDTH-1:0]         q_pos,
  output logic [WIDTH-1:0]         q_neg
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0]   pos_q, pos_d;
  logic [WIDTH-1:0]   neg_q;
  logic               en_d_q, en_d_d;
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic [2*WIDTH-1:0] mem_q [DEPTH];

  logic               push;
  logic               pop;
  logic               acc;
  logic [2*WIDTH-1:0] word;

  // en_d_q marks a beat whose posedge sample is in pos_q; its negedge
  // partner lands in neg_q before the next posedge, where the pair is pushed.
  always_comb begin
    pos_d   = en ? data : pos_q;
    en_d_d  = en;
    push    = en_d_q;
    pop     = (level_q != '0) && out_ready;
    acc     = push && ((level_q != FULL) || pop);
    word    = (DDR != 0) ? {neg_q, pos_q}
                         : {{WIDTH{1'b0}}, pos_q};
    wptr_d  = acc ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    unique case ({acc, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    ovf_d   = ovf_q | (push & ~acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q   <= POS_INIT;
      en_d_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      en_d_q  <= en_d_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      if (acc) mem_q[wptr_q] <= word;
    end
  end

  // In SDR mode the negedge register never captures.
  always_ff @(negedge clk) begin
    if (rst || DDR == 0) begin
      neg_q <= NEG_INIT;
    end else if (en_d_q) begin
      neg_q <= data;
    end
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rptr_q] : '0;
  assign out_level = level_q;
  assign overflow  = ovf_q;
  assign q_pos     = pos_q;
  assign q_neg     = neg_q;

endmodule

// File: tb/tb_ddr_capture_fifo.sv
// Directed bench for ddr_capture_fifo: DDR instance driven by a vector
// table plus hand sequences; an SDR instance shares the same inputs.
module tb_ddr_capture_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        rdy = 1'b0;

  logic        v0, v1;
  logic [15:0] d0, d1;
  logic [2:0]  l0, l1;
  logic        o0, o1;
  logic [7:0]  qp0, qn0, qp1, qn1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ddr_capture_fifo #(.WIDTH(8), .DEPTH(4), .DDR(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .data(data), .out_ready(rdy),
    .out_valid(v0), .out_data(d0), .out_level(l0), .overflow(o0),
    .q_pos(qp0), .q_neg(qn0)
  );

  ddr_capture_fifo #(.WIDTH(8), .DEPTH(4), .DDR(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .data(data), .out_ready(rdy),
    .out_valid(v1), .out_data(d1), .out_level(l1), .overflow(o1),
    .q_pos(qp1), .q_neg(qn1)
  );

  typedef struct {
    logic        e;
    logic [7:0]  p;
    logic [7:0]  n;
    logic        r;
    logic        xv;
    logic [15:0] xd;
    logic [2:0]  xl;
    logic        xo;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Starts and ends 1 time unit after a negedge.
  task automatic beat(input logic e, input logic [7:0] p,
                      input logic [7:0] n);
    en = e;
    data = p;
    @(posedge clk);
    #1 data = n;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_fifo(input string nm, input logic xv,
                          input logic [15:0] xd, input logic [2:0] xl,
                          input logic xo);
    chk({nm, ".valid"}, 32'(v0), 32'(xv));
    chk({nm, ".data"}, 32'(d0), 32'(xd));
    chk({nm, ".level"}, 32'(l0), 32'(xl));
    chk({nm, ".ovf"}, 32'(o0), 32'(xo));
  endtask

  initial begin
    vt[0]  = '{1, 8'h12, 8'h34, 0, 0, 16'h0000, 0, 0};
    vt[1]  = '{0, 8'h00, 8'h00, 0, 1, 16'h3412, 1, 0};
    vt[2]  = '{0, 8'h00, 8'h00, 1, 0, 16'h0000, 0, 0};
    vt[3]  = '{1, 8'h01, 8'h81, 0, 0, 16'h0000, 0, 0};
    vt[4]  = '{1, 8'h02, 8'h82, 0, 1, 16'h8101, 1, 0};
    vt[5]  = '{1, 8'h03, 8'h83, 0, 1, 16'h8101, 2, 0};
    vt[6]  = '{1, 8'h04, 8'h84, 0, 1, 16'h8101, 3, 0};
    vt[7]  = '{1, 8'h05, 8'h85, 0, 1, 16'h8101, 4, 0};
    vt[8]  = '{0, 8'h00, 8'h00, 0, 1, 16'h8101, 4, 1};
    vt[9]  = '{1, 8'hAA, 8'hBB, 0, 1, 16'h8101, 4, 1};
    vt[10] = '{0, 8'h00, 8'h00, 1, 1, 16'h8202, 4, 1};
    vt[11] = '{0, 8'h00, 8'h00, 1, 1, 16'h8303, 3, 1};
    vt[12] = '{0, 8'h00, 8'h00, 1, 1, 16'h8404, 2, 1};
    vt[13] = '{0, 8'h00, 8'h00, 1, 1, 16'hBBAA, 1, 1};
    vt[14] = '{0, 8'h00, 8'h00, 1, 0, 16'h0000, 0, 1};

    // Reset for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.q_pos", 32'(qp0), 32'h00);
    chk("rst.q_neg", 32'(qn0), 32'hFF);
    chk_fifo("rst", 0, 16'h0000, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      rdy = vt[i].r;
      beat(vt[i].e, vt[i].p, vt[i].n);
      chk_fifo($sformatf("vec%0d", i), vt[i].xv, vt[i].xd,
               vt[i].xl, vt[i].xo);
    end

    // Reset in the middle of an active beat with three words queued.
    rdy = 1'b0;
    beat(1, 8'h11, 8'h91);
    beat(1, 8'h22, 8'h92);
    beat(1, 8'h33, 8'h93);
    beat(1, 8'h44, 8'h94);
    chk_fifo("pre_rst", 1, 16'h9111, 3, 1);
    rst = 1'b1;
    en = 1'b1;
    data = 8'h66;
    @(posedge clk);
    #1;
    chk("mid_rst.level", 32'(l0), 32'd0);
    chk("mid_rst.ovf", 32'(o0), 32'd0);
    data = 8'h96;
    @(negedge clk);
    #1;
    chk("mid_rst.q_neg", 32'(qn0), 32'hFF);
    rst = 1'b0;
    beat(0, 8'h00, 8'h00);
    chk_fifo("post_rst0", 0, 16'h0000, 0, 0);
    beat(1, 8'h55, 8'h95);
    chk_fifo("post_rst1", 0, 16'h0000, 0, 0);
    beat(0, 8'h00, 8'h00);
    chk_fifo("post_rst2", 1, 16'h9555, 1, 0);
    rdy = 1'b1;
    beat(0, 8'h00, 8'h00);
    chk_fifo("post_rst3", 0, 16'h0000, 0, 0);

    // SDR instance: upper half zero, q_neg pinned at its init value.
    rdy = 1'b0;
    beat(1, 8'h5A, 8'hC3);
    chk("sdr.q_neg_a", 32'(qn1), 32'hFF);
    beat(0, 8'h00, 8'h00);
    chk("sdr.valid", 32'(v1), 32'd1);
    chk("sdr.data", 32'(d1), 32'h005A);
    chk("sdr.q_neg_b", 32'(qn1), 32'hFF);
    chk("ddr.data", 32'(d0), 32'hC35A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
